// File: rtl/instruction_fetch_q.sv
// Instruction fetch unit: one-outstanding syn/ack memory requests feeding a prefetch queue for decode.
// Optional FETCH_PERF_EN adds fetch/flush event counters.
module instruction_fetch_q #(
    parameter int unsigned          IWIDTH   = 32,
    parameter int unsigned          PC_WIDTH = 32,
    parameter int unsigned          QDEPTH   = 4,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = '0,
    parameter int unsigned          PC_STEP  = 4
) (
    input  logic                f_clk,
    input  logic                f_rst,
    input  logic                f_i_ce,
    input  logic                f_i_stall,
    input  logic                f_i_change_pc,
    input  logic [PC_WIDTH-1:0] f_i_alu_pc,
    output logic                f_o_syn,
    output logic [PC_WIDTH-1:0] f_o_addr,
    input  logic                f_i_ack,
    input  logic [IWIDTH-1:0]   f_i_instr,
    input  logic                f_i_last,
    output logic [IWIDTH-1:0]   f_o_instr,
    output logic [PC_WIDTH-1:0] f_o_pc,
    output logic                f_o_ce
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]         f_o_fetch_cnt,
    output logic [31:0]         f_o_flush_cnt
`endif
);

    localparam int unsigned          PTR_W   = $clog2(QDEPTH);
    localparam int unsigned          CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]     DEPTH_C = CNT_W'(QDEPTH);
    localparam logic [PC_WIDTH-1:0]  STEP_C  = PC_WIDTH'(PC_STEP);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t              state;
    logic [IWIDTH-1:0]   q_instr [QDEPTH];
    logic [PC_WIDTH-1:0] q_pc    [QDEPTH];
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr_nxt;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    count_nxt;
    logic [PC_WIDTH-1:0] fetch_pc;
    logic [PC_WIDTH-1:0] addr_inc;
    logic                discard;
    logic                push;
    logic                pop;
    logic                room_nxt;
    logic [IWIDTH-1:0]   head_instr;
    logic [PC_WIDTH-1:0] head_pc;

    // Queue bookkeeping and the head entry as it will look after this edge
    always_comb begin
        push       = (state == S_REQ) && f_i_ack && !discard && !f_i_change_pc;
        pop        = f_o_ce && !f_i_stall && !f_i_change_pc;
        count_nxt  = count + CNT_W'(push) - CNT_W'(pop);
        rd_ptr_nxt = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
        room_nxt   = count_nxt < DEPTH_C;
        addr_inc   = f_o_addr + STEP_C;
        head_instr = q_instr[rd_ptr_nxt];
        head_pc    = q_pc[rd_ptr_nxt];
        // Entry written this edge becomes head only when the queue drains to it
        if (push && (wr_ptr == rd_ptr_nxt)) begin
            head_instr = f_i_instr;
            head_pc    = f_o_addr;
        end
    end

    // Queue storage
    always_ff @(posedge f_clk) begin
        if (push) begin
            q_instr[wr_ptr] <= f_i_instr;
            q_pc[wr_ptr]    <= f_o_addr;
        end
    end

    // Fetch FSM, queue pointers and registered decode-side outputs
    always_ff @(posedge f_clk) begin
        if (f_rst) begin
            state     <= S_IDLE;
            f_o_syn   <= 1'b0;
            f_o_addr  <= RESET_PC;
            f_o_ce    <= 1'b0;
            f_o_instr <= '0;
            f_o_pc    <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            fetch_pc  <= RESET_PC;
            discard   <= 1'b0;
        end else if (f_i_change_pc) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            f_o_ce   <= 1'b0;
            fetch_pc <= f_i_alu_pc;
            if ((state == S_REQ) && !f_i_ack) begin
                // Request must complete on the bus; its response is dropped later
                discard <= 1'b1;
            end else begin
                discard <= 1'b0;
                if (f_i_ce) begin
                    state    <= S_REQ;
                    f_o_syn  <= 1'b1;
                    f_o_addr <= f_i_alu_pc;
                end else begin
                    state   <= S_IDLE;
                    f_o_syn <= 1'b0;
                end
            end
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            f_o_ce <= (count_nxt != '0);
            if (count_nxt != '0) begin
                f_o_instr <= head_instr;
                f_o_pc    <= head_pc;
            end
            case (state)
                S_IDLE: begin
                    if (f_i_ce && (count < DEPTH_C)) begin
                        state    <= S_REQ;
                        f_o_syn  <= 1'b1;
                        f_o_addr <= fetch_pc;
                    end
                end
                S_REQ: begin
                    if (f_i_ack) begin
                        if (discard) begin
                            discard <= 1'b0;
                            if (f_i_ce && room_nxt) begin
                                f_o_addr <= fetch_pc;
                            end else begin
                                state   <= S_IDLE;
                                f_o_syn <= 1'b0;
                            end
                        end else begin
                            fetch_pc <= addr_inc;
                            if (f_i_last) begin
                                state   <= S_HALT;
                                f_o_syn <= 1'b0;
                            end else if (f_i_ce && room_nxt) begin
                                f_o_addr <= addr_inc;
                            end else begin
                                state   <= S_IDLE;
                                f_o_syn <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    // Event counters, free-running modulo 2^32
    always_ff @(posedge f_clk) begin
        if (f_rst) begin
            f_o_fetch_cnt <= '0;
            f_o_flush_cnt <= '0;
        end else begin
            if (push) begin
                f_o_fetch_cnt <= f_o_fetch_cnt + 32'd1;
            end
            if (f_i_change_pc) begin
                f_o_flush_cnt <= f_o_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_q.sv
// Self-checking bench for instruction_fetch_q: memory responder model plus expected-entry scoreboard.
module tb_instruction_fetch_q;

    localparam int unsigned IW = 32;
    localparam int unsigned PW = 8;

    logic          f_clk;
    logic          f_rst;
    logic          f_i_ce;
    logic          f_i_stall;
    logic          f_i_change_pc;
    logic [PW-1:0] f_i_alu_pc;
    logic          f_o_syn;
    logic [PW-1:0] f_o_addr;
    logic          f_i_ack;
    logic [IW-1:0] f_i_instr;
    logic          f_i_last;
    logic [IW-1:0] f_o_instr;
    logic [PW-1:0] f_o_pc;
    logic          f_o_ce;
`ifdef FETCH_PERF_EN
    logic [31:0]   f_o_fetch_cnt;
    logic [31:0]   f_o_flush_cnt;
`endif

    instruction_fetch_q #(
        .IWIDTH   (IW),
        .PC_WIDTH (PW),
        .QDEPTH   (4),
        .RESET_PC (8'h00),
        .PC_STEP  (4)
    ) dut (
        .f_clk         (f_clk),
        .f_rst         (f_rst),
        .f_i_ce        (f_i_ce),
        .f_i_stall     (f_i_stall),
        .f_i_change_pc (f_i_change_pc),
        .f_i_alu_pc    (f_i_alu_pc),
        .f_o_syn       (f_o_syn),
        .f_o_addr      (f_o_addr),
        .f_i_ack       (f_i_ack),
        .f_i_instr     (f_i_instr),
        .f_i_last      (f_i_last),
        .f_o_instr     (f_o_instr),
        .f_o_pc        (f_o_pc),
        .f_o_ce        (f_o_ce)
`ifdef FETCH_PERF_EN
        ,
        .f_o_fetch_cnt (f_o_fetch_cnt),
        .f_o_flush_cnt (f_o_flush_cnt)
`endif
    );

    initial f_clk = 1'b0;
    always #5 f_clk = ~f_clk;

    int              checks;
    int              errors;
    int              pushes;
    logic [IW+PW-1:0] exp_q[$];
    logic [PW-1:0]   popped[$];
    logic [PW-1:0]   model_pc;
    logic            model_discard;
    logic            hold_en;
    logic [PW-1:0]   hold_addr;
    logic            last_en;
    logic [PW-1:0]   last_pc;

    // One clock: memory responds, scoreboard pushes/pops, then the edge
    task automatic tick();
        logic [IW+PW-1:0] e;
        f_i_ack = 1'b0;
        if (f_o_syn && !(hold_en && f_o_addr == hold_addr)) begin
            f_i_ack   = 1'b1;
            f_i_instr = 32'h1000_0000 + 32'(f_o_addr);
            f_i_last  = last_en && (f_o_addr == last_pc);
            if (model_discard) begin
                model_discard = 1'b0;
            end else begin
                checks++;
                if (f_o_addr !== model_pc) begin
                    errors++;
                    $display("FAIL req_addr: got %h want %h", f_o_addr, model_pc);
                end
                if (!f_i_change_pc) begin
                    exp_q.push_back({32'h1000_0000 + 32'(model_pc), model_pc});
                    pushes++;
                end
                model_pc = model_pc + PW'(4);
            end
        end
        if (f_o_ce && !f_i_stall && !f_i_change_pc) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got pc %h instr %h want no entry", f_o_pc, f_o_instr);
            end else begin
                e = exp_q.pop_front();
                if ({f_o_instr, f_o_pc} !== e) begin
                    errors++;
                    $display("FAIL head_entry: got %h/%h want %h/%h", f_o_instr, f_o_pc, e[IW+PW-1:PW], e[PW-1:0]);
                end
            end
            popped.push_back(f_o_pc);
        end
        if (f_i_change_pc) begin
            exp_q.delete();
            model_pc = f_i_alu_pc;
            if (f_o_syn && !f_i_ack) model_discard = 1'b1;
        end
        @(posedge f_clk);
        #1;
        f_i_ack       = 1'b0;
        f_i_last      = 1'b0;
        f_i_change_pc = 1'b0;
        checks++;
        if (f_o_ce !== (exp_q.size() != 0)) begin
            errors++;
            $display("FAIL out_valid: got %b want %b", f_o_ce, exp_q.size() != 0);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        model_pc      = 8'h00;
        model_discard = 1'b0;
        hold_en       = 1'b0;
        last_en       = 1'b0;
    endtask

    task automatic do_reset();
        f_rst = 1'b1; f_i_ce = 1'b0; f_i_stall = 1'b0;
        f_i_change_pc = 1'b0; f_i_ack = 1'b0; f_i_last = 1'b0;
        repeat (2) begin @(posedge f_clk); #1; end
        f_rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        f_rst = 1'b1; f_i_ce = 1'b1; f_i_stall = 1'b0;
        f_i_change_pc = 1'b0; f_i_ack = 1'b0; f_i_last = 1'b0;
        repeat (2) begin @(posedge f_clk); #1; end
        checks++;
        if ({f_o_syn, f_o_addr, f_o_ce, f_o_instr, f_o_pc} !== {1'b0, 8'h00, 1'b0, 32'h0, 8'h00}) begin
            errors++;
            $display("FAIL reset_state: got syn %b addr %h ce %b instr %h pc %h want 0/00/0/0/00",
                     f_o_syn, f_o_addr, f_o_ce, f_o_instr, f_o_pc);
        end
        f_rst = 1'b0; f_i_ce = 1'b0;
        model_reset();
    endtask

    task automatic test_stream();
        do_reset();
        f_i_ce = 1'b1;
        popped.delete();
        repeat (12) tick();
        checks++;
        if (popped.size() < 4) begin
            errors++;
            $display("FAIL stream_count: got %0d want >=4", popped.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (popped[i] !== PW'(i * 4)) begin
                    errors++;
                    $display("FAIL stream_order: got %h want %h", popped[i], PW'(i * 4));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        f_i_ce = 1'b1; f_i_stall = 1'b1; pushes = 0;
        repeat (12) tick();
        checks++;
        if (pushes != 4) begin
            errors++;
            $display("FAIL bp_fill: got %0d pushes want 4", pushes);
        end
        checks++;
        if (f_o_syn !== 1'b0) begin
            errors++;
            $display("FAIL bp_syn_full: got %b want 0", f_o_syn);
        end
        f_i_stall = 1'b0;
        popped.delete();
        repeat (12) tick();
        checks++;
        if (popped.size() < 5) begin
            errors++;
            $display("FAIL bp_drain: got %0d pops want >=5", popped.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (popped[i] !== PW'(i * 4)) begin
                    errors++;
                    $display("FAIL bp_order: got %h want %h", popped[i], PW'(i * 4));
                end
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        f_i_ce = 1'b1; hold_en = 1'b1; hold_addr = 8'h08;
        for (int i = 0; i < 20 && !(f_o_syn && f_o_addr == 8'h08); i++) tick();
        checks++;
        if (!(f_o_syn === 1'b1 && f_o_addr === 8'h08)) begin
            errors++;
            $display("FAIL redir_wait: got syn %b addr %h want 1/08", f_o_syn, f_o_addr);
        end
        f_i_change_pc = 1'b1; f_i_alu_pc = 8'h40;
        tick();
        checks++;
        if ({f_o_ce, f_o_syn, f_o_addr} !== {1'b0, 1'b1, 8'h08}) begin
            errors++;
            $display("FAIL redir_hold: got ce %b syn %b addr %h want 0/1/08", f_o_ce, f_o_syn, f_o_addr);
        end
        repeat (2) tick();
        hold_en = 1'b0;
        popped.delete();
        tick();
        checks++;
        if ({f_o_ce, f_o_syn, f_o_addr} !== {1'b0, 1'b1, 8'h40}) begin
            errors++;
            $display("FAIL redir_next: got ce %b syn %b addr %h want 0/1/40", f_o_ce, f_o_syn, f_o_addr);
        end
        repeat (6) tick();
        checks++;
        if (popped.size() == 0 || popped[0] !== 8'h40) begin
            errors++;
            $display("FAIL redir_first_pc: got %h want 40", popped.size() ? popped[0] : 8'hxx);
        end
    endtask

    task automatic test_last();
        do_reset();
        f_i_ce = 1'b1; last_en = 1'b1; last_pc = 8'h0C;
        popped.delete();
        repeat (8) tick();
        checks++;
        if (popped.size() != 4 || popped[3] !== 8'h0C) begin
            errors++;
            $display("FAIL last_delivered: got %0d pops want 4 ending at 0c", popped.size());
        end
        repeat (12) begin
            tick();
            checks++;
            if (f_o_syn !== 1'b0) begin
                errors++;
                $display("FAIL halt_syn: got %b want 0", f_o_syn);
            end
        end
        last_en = 1'b0;
        f_i_change_pc = 1'b1; f_i_alu_pc = 8'h00;
        popped.delete();
        repeat (9) tick();
        checks++;
        if (popped.size() < 2 || popped[0] !== 8'h00 || popped[1] !== 8'h04) begin
            errors++;
            $display("FAIL halt_restart: got %0d pops want >=2 starting 00,04", popped.size());
        end
    endtask

    task automatic test_wrap();
        logic [PW-1:0] want[3];
        want[0] = 8'hFC; want[1] = 8'h00; want[2] = 8'h04;
        do_reset();
        f_i_ce = 1'b1;
        repeat (4) tick();
        f_i_change_pc = 1'b1; f_i_alu_pc = 8'hFC;
        popped.delete();
        repeat (9) tick();
        checks++;
        if (popped.size() < 3) begin
            errors++;
            $display("FAIL wrap_count: got %0d want >=3", popped.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (popped[i] !== want[i]) begin
                    errors++;
                    $display("FAIL wrap_order: got %h want %h", popped[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        f_i_ce = 1'b1; hold_en = 1'b1; hold_addr = 8'h04;
        for (int i = 0; i < 20 && !(f_o_syn && f_o_addr == 8'h04); i++) tick();
        f_rst = 1'b1; f_i_ack = 1'b1; f_i_instr = 32'h1000_0004;
        @(posedge f_clk);
        #1;
        f_i_ack = 1'b0;
        checks++;
        if ({f_o_syn, f_o_ce, f_o_addr} !== {1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_mid: got syn %b ce %b addr %h want 0/0/00", f_o_syn, f_o_ce, f_o_addr);
        end
        f_rst = 1'b0;
        model_reset();
        popped.delete();
        repeat (6) tick();
        checks++;
        if (popped.size() == 0 || popped[0] !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_restart: got %0d pops want first pc 00", popped.size());
        end
    endtask

    initial begin
        checks = 0; errors = 0; pushes = 0;
        f_rst = 1'b1; f_i_ce = 1'b0; f_i_stall = 1'b0; f_i_change_pc = 1'b0;
        f_i_alu_pc = '0; f_i_ack = 1'b0; f_i_instr = '0; f_i_last = 1'b0;
        hold_addr = '0; last_pc = '0;
        model_reset();
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_last();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_q.md
Name: instruction_fetch_q

Overview:
Parametrised next-generation instruction fetch unit with a QDEPTH-entry prefetch queue between instruction memory and decode. It issues one-outstanding-request syn/ack transactions to instruction memory and buffers returned instruction/PC pairs. It presents them to decode with a valid/stall handshake. It supports PC redirect (branch/jump) with flush and in-flight discard, and an end-of-program halt.

Parameters:
IWIDTH, 32, instruction width in bits
PC_WIDTH, 32, PC/address width in bits
QDEPTH, 4, prefetch queue entries (power of two, >=2)
RESET_PC, 0, PC value loaded on reset
PC_STEP, 4, PC increment per fetched instruction

Ports:
f_clk  in  1  clock, all logic on rising edge
f_rst  in  1  synchronous, active-high reset
f_i_ce  in  1  fetch enable; low = issue no new requests
f_i_stall  in  1  decode not ready; blocks pop
f_i_change_pc  in  1  redirect strobe (one cycle)
f_i_alu_pc  in  PC_WIDTH  redirect target
f_o_syn  out  1  memory request valid
f_o_addr  out  PC_WIDTH  memory request address
f_i_ack  in  1  memory response valid
f_i_instr  in  IWIDTH  memory response data
f_i_last  in  1  response is last instruction of program (qualified by f_i_ack)
f_o_instr  out  IWIDTH  instruction at queue head
f_o_pc  out  PC_WIDTH  PC of f_o_instr
f_o_ce  out  1  f_o_instr/f_o_pc valid

Behaviour:
- Reset (f_rst=1 at edge): f_o_syn=0, f_o_addr=RESET_PC, f_o_ce=0, f_o_instr=0, f_o_pc=0, queue empty, fetch_pc=RESET_PC, discard=0, state IDLE. Reset mid-request drops f_o_syn on that edge; the pending ack is ignored.
- States: IDLE (no request), REQ (f_o_syn=1, waiting for ack), HALT (last seen, no requests).
- IDLE->REQ when f_i_ce=1 and (count + 0) < QDEPTH: next edge f_o_syn=1, f_o_addr=fetch_pc.
- REQ: f_o_syn and f_o_addr held stable until f_i_ack=1. On ack: push {f_i_instr, f_o_addr} unless discard; fetch_pc = f_o_addr + PC_STEP, modulo 2^PC_WIDTH. If f_i_ce=1 and room remains (count after push < QDEPTH), stay in REQ with the new address on the next edge (back-to-back, one instruction/cycle max); else go to IDLE with f_o_syn=0.
- Room accounting counts the outstanding request, so the queue never overflows. A push to a full queue is impossible by construction.
- Output: f_o_ce=1 iff queue non-empty; f_o_instr/f_o_pc = head entry from registered storage. Pop on f_o_ce & ~f_i_stall. Simultaneous push and pop leaves count unchanged. Latency: ack at edge N into an empty queue gives f_o_ce=1 after edge N.
- Empty: f_o_ce=0; f_o_instr/f_o_pc hold last value (don't-care).
- f_i_change_pc (priority over push/pop): on that edge the queue is flushed (f_o_ce=0 after edge), fetch_pc=f_i_alu_pc, and HALT exits.
  - If in REQ without a same-cycle ack: discard=1. Request held until ack, response dropped, discard cleared, then a request to f_i_alu_pc is issued.
  - If ack in same cycle: response dropped. Next request is at f_i_alu_pc.
  - If IDLE: next request is at f_i_alu_pc.
- f_i_last with non-discarded ack: instruction enqueued, state HALT, f_o_syn=0. Queue keeps draining. Exit HALT only via reset or redirect.
- f_i_ce low: outstanding request completes normally; no new request issued.
- Queue pointers log2(QDEPTH) bits, wrap naturally. Count is log2(QDEPTH)+1 bits.

Optional Feature:
FETCH_PERF_EN: when defined, adds outputs f_o_fetch_cnt (32) and f_o_flush_cnt (32).
- f_o_fetch_cnt increments on each non-discarded ack.
- f_o_flush_cnt increments on each f_i_change_pc.
- Both counters clear on f_rst and wrap at 2^32.
When undefined, neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- Reset then stream: RESET_PC=0, ack every cycle, f_i_stall=0, instr = 0x1000_0000+addr -> f_o_pc sequence 0,4,8,12 with matching f_o_instr; first f_o_ce one cycle after first ack.
- Backpressure: f_i_stall=1 with QDEPTH=4 -> exactly 4 entries pushed, f_o_syn=0 while full; release stall -> entries pop in order 0,4,8,12 and fetching resumes at 16.
- Redirect mid-flight: request to 8 outstanding, f_i_change_pc=1 with f_i_alu_pc=0x40, ack 3 cycles later -> that response dropped, f_o_ce=0, next f_o_addr=0x40, next f_o_pc=0x40.
- Last: f_i_last=1 with ack at addr 12 -> entry 12 delivered, f_o_syn stays 0 for 10+ cycles; redirect to 0 -> fetching restarts at 0.
- Wrap: PC_WIDTH=8, redirect to 0xFC -> f_o_pc sequence 0xFC, 0x00, 0x04.
- Reset mid-request: f_rst=1 while f_o_syn=1 -> f_o_syn=0, f_o_ce=0 after edge; after release, first f_o_addr=RESET_PC.
